// File: rtl/fetch_queue.sv
// fetch_queue: DEPTH-entry circular buffer of {pc, instr} pairs between fetch
// and decode, valid/ready on both sides, synchronous flush on redirect.
// Optional macro FETCH_QUEUE_BYPASS_EN: an empty queue forwards the incoming
// entry combinationally to the dequeue side in the same cycle.
module fetch_queue #(
    parameter int DEPTH = 4,
    parameter int XLEN  = 64
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     flush_i,
    input  logic                     enq_valid_i,
    input  logic [XLEN-1:0]          enq_pc_i,
    input  logic [31:0]              enq_instr_i,
    output logic                     enq_ready_o,
    output logic                     deq_valid_o,
    output logic [XLEN-1:0]          deq_pc_o,
    output logic [31:0]              deq_instr_o,
    input  logic                     deq_ready_i,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);
    localparam logic [CW-1:0] CNT_ONE    = CW'(1);
    localparam logic [PW-1:0] PTR_ONE    = PW'(1);

    logic [XLEN-1:0] mem_pc    [DEPTH];
    logic [31:0]     mem_instr [DEPTH];

    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr;
    logic [CW-1:0] count;

    logic empty;
    logic do_write;
    logic do_pop;

    assign empty       = (count == '0);
    assign enq_ready_o = (count != FULL_COUNT);
    assign count_o     = count;

`ifdef FETCH_QUEUE_BYPASS_EN
    logic bypass;
    logic bypass_take;

    // Empty queue forwards the fetch entry directly; a consumed forward is never stored.
    always_comb begin
        bypass      = empty & enq_valid_i & ~flush_i & ~reset;
        bypass_take = bypass & deq_ready_i;
        deq_valid_o = ~empty | bypass;
        deq_pc_o    = '0;
        deq_instr_o = '0;
        if (!empty) begin
            deq_pc_o    = mem_pc[rd_ptr];
            deq_instr_o = mem_instr[rd_ptr];
        end else if (bypass) begin
            deq_pc_o    = enq_pc_i;
            deq_instr_o = enq_instr_i;
        end
        do_write = enq_valid_i & enq_ready_o & ~bypass_take;
        do_pop   = deq_ready_i & ~empty;
    end
`else
    // Head entry falls through from storage; zeros while empty.
    always_comb begin
        deq_valid_o = ~empty;
        deq_pc_o    = '0;
        deq_instr_o = '0;
        if (!empty) begin
            deq_pc_o    = mem_pc[rd_ptr];
            deq_instr_o = mem_instr[rd_ptr];
        end
        do_write = enq_valid_i & enq_ready_o;
        do_pop   = deq_ready_i & ~empty;
    end
`endif

    // Storage write at the tail; contents are not cleared by reset or flush.
    always_ff @(posedge clk) begin
        if (do_write && !flush_i && !reset) begin
            mem_pc[wr_ptr]    <= enq_pc_i;
            mem_instr[wr_ptr] <= enq_instr_i;
        end
    end

    // Pointer and occupancy update; reset and flush discard everything.
    always_ff @(posedge clk) begin
        if (reset || flush_i) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_write) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            if (do_write && !do_pop) begin
                count <= count + CNT_ONE;
            end else if (!do_write && do_pop) begin
                count <= count - CNT_ONE;
            end
        end
    end

endmodule

// File: tb/tb_fetch_queue.sv
// Self-checking bench for fetch_queue (DEPTH=4, XLEN=64) using a scoreboard
// queue of expected {pc, instr} entries.
module tb_fetch_queue;

    logic        clk = 1'b0;
    logic        reset;
    logic        flush_i;
    logic        enq_valid_i;
    logic [63:0] enq_pc_i;
    logic [31:0] enq_instr_i;
    logic        enq_ready_o;
    logic        deq_valid_o;
    logic [63:0] deq_pc_o;
    logic [31:0] deq_instr_o;
    logic        deq_ready_i;
    logic [2:0]  count_o;

    int total = 0;
    int bad   = 0;

    logic [95:0] sb[$];
    logic [95:0] exp_e;

    fetch_queue #(.DEPTH(4), .XLEN(64)) dut (
        .clk         (clk),
        .reset       (reset),
        .flush_i     (flush_i),
        .enq_valid_i (enq_valid_i),
        .enq_pc_i    (enq_pc_i),
        .enq_instr_i (enq_instr_i),
        .enq_ready_o (enq_ready_o),
        .deq_valid_o (deq_valid_o),
        .deq_pc_o    (deq_pc_o),
        .deq_instr_o (deq_instr_o),
        .deq_ready_i (deq_ready_i),
        .count_o     (count_o)
    );

    always #5 clk = ~clk;

    // Advance one clock while updating the reference model from the current inputs.
    task automatic tick();
        bit byp;
        bit efire;
        bit dfire;
        byp = 1'b0;
`ifdef FETCH_QUEUE_BYPASS_EN
        byp = (sb.size() == 0) && enq_valid_i && deq_ready_i && !flush_i && !reset;
`endif
        efire = enq_valid_i && (sb.size() != 4) && !byp;
        dfire = deq_ready_i && (sb.size() != 0);
        if (reset || flush_i) begin
            sb.delete();
        end else begin
            if (dfire) void'(sb.pop_front());
            if (efire) sb.push_back({enq_pc_i, enq_instr_i});
        end
        @(posedge clk);
        #1;
    endtask

    task automatic set_in(input bit ev, input logic [63:0] pc, input logic [31:0] ins, input bit dr);
        enq_valid_i = ev;
        enq_pc_i    = pc;
        enq_instr_i = ins;
        deq_ready_i = dr;
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        flush_i = 1'b0;
        set_in(1'b1, 64'hDEAD, 32'h1, 1'b0);
        for (int i = 0; i < 2; i++) begin
            tick();
            total++; if (enq_ready_o !== 1'b1) begin bad++; $display("FAIL reset_ready got=%b exp=1", enq_ready_o); end
            total++; if (deq_valid_o !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b exp=0", deq_valid_o); end
            total++; if (count_o !== 3'd0) begin bad++; $display("FAIL reset_count got=%0d exp=0", count_o); end
            total++; if (deq_pc_o !== 64'd0) begin bad++; $display("FAIL reset_pc got=%h exp=0", deq_pc_o); end
        end
        reset = 1'b0;
        set_in(1'b0, 64'h0, 32'h0, 1'b0);
        tick();
        total++; if (count_o !== 3'd0 || deq_valid_o !== 1'b0 || deq_instr_o !== 32'd0) begin
            bad++; $display("FAIL post_reset count=%0d valid=%b instr=%h exp 0/0/0", count_o, deq_valid_o, deq_instr_o);
        end
    endtask

    task automatic test_fill();
        for (int i = 0; i < 4; i++) begin
            set_in(1'b1, 64'h1000 + 64'(4 * i), 32'h13 + 32'(i), 1'b0);
            total++; if (enq_ready_o !== 1'b1) begin bad++; $display("FAIL fill_ready%0d got=%b exp=1", i, enq_ready_o); end
            tick();
        end
        total++; if (count_o !== 3'd4) begin bad++; $display("FAIL fill_count got=%0d exp=4", count_o); end
        total++; if (enq_ready_o !== 1'b0) begin bad++; $display("FAIL full_ready got=%b exp=0", enq_ready_o); end
        set_in(1'b1, 64'h1010, 32'h17, 1'b0);
        tick();
        total++; if (count_o !== 3'd4) begin bad++; $display("FAIL overfill_count got=%0d exp=4", count_o); end
        for (int i = 0; i < 4; i++) begin
            set_in(1'b0, 64'h0, 32'h0, 1'b1);
            exp_e = sb[0];
            total++; if (deq_valid_o !== 1'b1) begin bad++; $display("FAIL drain_valid%0d got=%b exp=1", i, deq_valid_o); end
            total++; if (deq_pc_o !== 64'h1000 + 64'(4 * i) || deq_pc_o !== exp_e[95:32]) begin
                bad++; $display("FAIL drain_pc%0d got=%h exp=%h", i, deq_pc_o, 64'h1000 + 64'(4 * i));
            end
            total++; if (deq_instr_o !== exp_e[31:0]) begin bad++; $display("FAIL drain_instr%0d got=%h exp=%h", i, deq_instr_o, exp_e[31:0]); end
            tick();
        end
        set_in(1'b0, 64'h0, 32'h0, 1'b0);
        total++; if (deq_valid_o !== 1'b0 || count_o !== 3'd0 || deq_pc_o !== 64'd0) begin
            bad++; $display("FAIL drained valid=%b count=%0d pc=%h exp 0/0/0", deq_valid_o, count_o, deq_pc_o);
        end
    endtask

    task automatic test_simultaneous();
        logic [63:0] prev;
        for (int i = 0; i < 2; i++) begin
            set_in(1'b1, 64'h4000 + 64'(4 * i), 32'h4000 + 32'(i), 1'b0);
            tick();
        end
        prev = 64'h3FFC;
        for (int i = 2; i < 12; i++) begin
            set_in(1'b1, 64'h4000 + 64'(4 * i), 32'h4000 + 32'(i), 1'b1);
            exp_e = sb[0];
            total++; if (count_o !== 3'd2) begin bad++; $display("FAIL simul_count%0d got=%0d exp=2", i, count_o); end
            total++; if (deq_pc_o !== exp_e[95:32] || deq_pc_o !== prev + 64'd4) begin
                bad++; $display("FAIL simul_pc%0d got=%h exp=%h", i, deq_pc_o, exp_e[95:32]);
            end
            total++; if (deq_instr_o !== exp_e[31:0]) begin bad++; $display("FAIL simul_instr%0d got=%h exp=%h", i, deq_instr_o, exp_e[31:0]); end
            prev = deq_pc_o;
            tick();
        end
        while (sb.size() != 0) begin
            set_in(1'b0, 64'h0, 32'h0, 1'b1);
            exp_e = sb[0];
            total++; if (deq_pc_o !== exp_e[95:32]) begin bad++; $display("FAIL simul_drain got=%h exp=%h", deq_pc_o, exp_e[95:32]); end
            tick();
        end
        set_in(1'b0, 64'h0, 32'h0, 1'b0);
        total++; if (count_o !== 3'd0) begin bad++; $display("FAIL simul_empty got=%0d exp=0", count_o); end
    endtask

    task automatic test_full_deq();
        for (int i = 0; i < 4; i++) begin
            set_in(1'b1, 64'h5000 + 64'(4 * i), 32'h5000 + 32'(i), 1'b0);
            tick();
        end
        set_in(1'b1, 64'h5010, 32'h5004, 1'b1);
        total++; if (enq_ready_o !== 1'b0) begin bad++; $display("FAIL fulldeq_ready got=%b exp=0", enq_ready_o); end
        tick();
        set_in(1'b1, 64'h5010, 32'h5004, 1'b0);
        total++; if (count_o !== 3'd3 || enq_ready_o !== 1'b1) begin
            bad++; $display("FAIL fulldeq_after count=%0d ready=%b exp 3/1", count_o, enq_ready_o);
        end
        tick();
        total++; if (count_o !== 3'd4) begin bad++; $display("FAIL fulldeq_accept got=%0d exp=4", count_o); end
        while (sb.size() != 0) begin
            set_in(1'b0, 64'h0, 32'h0, 1'b1);
            exp_e = sb[0];
            total++; if (deq_pc_o !== exp_e[95:32] || deq_instr_o !== exp_e[31:0]) begin
                bad++; $display("FAIL fulldeq_drain got=%h/%h exp=%h/%h", deq_pc_o, deq_instr_o, exp_e[95:32], exp_e[31:0]);
            end
            tick();
        end
    endtask

    task automatic test_flush();
        for (int i = 0; i < 3; i++) begin
            set_in(1'b1, 64'h6000 + 64'(4 * i), 32'h6000 + 32'(i), 1'b0);
            tick();
        end
        flush_i = 1'b1;
        set_in(1'b1, 64'h2000, 32'h2000, 1'b1);
        total++; if (deq_valid_o !== 1'b1 || deq_pc_o !== 64'h6000 || count_o !== 3'd3) begin
            bad++; $display("FAIL flush_pre valid=%b pc=%h count=%0d exp 1/6000/3", deq_valid_o, deq_pc_o, count_o);
        end
        tick();
        flush_i = 1'b0;
        for (int i = 0; i < 3; i++) begin
            set_in(1'b0, 64'h0, 32'h0, 1'b1);
            total++; if (count_o !== 3'd0 || deq_valid_o !== 1'b0 || deq_pc_o !== 64'd0) begin
                bad++; $display("FAIL flush_post%0d count=%0d valid=%b pc=%h exp 0/0/0", i, count_o, deq_valid_o, deq_pc_o);
            end
            tick();
        end
        set_in(1'b1, 64'h6100, 32'h6100, 1'b0);
        tick();
        set_in(1'b0, 64'h0, 32'h0, 1'b1);
        exp_e = sb[0];
        total++; if (deq_pc_o !== 64'h6100 || deq_pc_o !== exp_e[95:32]) begin
            bad++; $display("FAIL flush_next got=%h exp=6100", deq_pc_o);
        end
        tick();
        reset = 1'b0;
        for (int i = 0; i < 2; i++) begin
            set_in(1'b1, 64'h7000 + 64'(4 * i), 32'h7000, 1'b0);
            tick();
        end
        reset = 1'b1;
        set_in(1'b0, 64'h0, 32'h0, 1'b0);
        tick();
        reset = 1'b0;
        set_in(1'b0, 64'h0, 32'h0, 1'b1);
        total++; if (count_o !== 3'd0 || deq_valid_o !== 1'b0) begin
            bad++; $display("FAIL reset_midfill count=%0d valid=%b exp 0/0", count_o, deq_valid_o);
        end
        tick();
    endtask

    task automatic test_bypass();
        set_in(1'b1, 64'h3000, 32'h00A00093, 1'b1);
`ifdef FETCH_QUEUE_BYPASS_EN
        total++; if (deq_valid_o !== 1'b1 || deq_pc_o !== 64'h3000 || deq_instr_o !== 32'h00A00093) begin
            bad++; $display("FAIL bypass_fwd valid=%b pc=%h instr=%h exp 1/3000/00a00093", deq_valid_o, deq_pc_o, deq_instr_o);
        end
        total++; if (count_o !== 3'd0) begin bad++; $display("FAIL bypass_count got=%0d exp=0", count_o); end
        tick();
        set_in(1'b0, 64'h0, 32'h0, 1'b0);
        total++; if (count_o !== 3'd0 || deq_valid_o !== 1'b0) begin
            bad++; $display("FAIL bypass_after count=%0d valid=%b exp 0/0", count_o, deq_valid_o);
        end
`else
        total++; if (deq_valid_o !== 1'b0) begin bad++; $display("FAIL nobyp_same got=%b exp=0", deq_valid_o); end
        tick();
        set_in(1'b0, 64'h0, 32'h0, 1'b0);
        exp_e = sb[0];
        total++; if (deq_valid_o !== 1'b1 || count_o !== 3'd1 || deq_pc_o !== exp_e[95:32]) begin
            bad++; $display("FAIL nobyp_next valid=%b count=%0d pc=%h exp 1/1/3000", deq_valid_o, count_o, deq_pc_o);
        end
        set_in(1'b0, 64'h0, 32'h0, 1'b1);
        tick();
        set_in(1'b0, 64'h0, 32'h0, 1'b0);
        total++; if (count_o !== 3'd0) begin bad++; $display("FAIL nobyp_drain got=%0d exp=0", count_o); end
`endif
    endtask

    initial begin
        reset = 1'b1;
        flush_i = 1'b0;
        enq_valid_i = 1'b0;
        enq_pc_i = '0;
        enq_instr_i = '0;
        deq_ready_i = 1'b0;
        test_reset();
        test_fill();
        test_simultaneous();
        test_full_deq();
        test_flush();
        test_bypass();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
